// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode/execute front end.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_EQ
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU; b carries rt or the prepared immediate.
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Select the operation; unknown ops produce zero so the block acts as a no-op
    always_comb begin
        result = 32'h0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = (a_s < b_s) ? 32'd1 : 32'd0;
            ALU_SLTU: result = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = b_s >>> shamt;
            ALU_LUI:  result = {b[15:0], 16'h0};
            ALU_EQ:   result = (a == b) ? 32'd1 : 32'd0;
            default:  result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS front end: field split, control decode, ALU and PC register.
module mips_decode_execute
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic [31:0] pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic        reg_read,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch_signal,
    output logic [31:0] alu_result
);

    alu_op_t     alu_op;
    logic [31:0] operand_b;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] next_pc;

    assign opcode    = instruction[31:26];
    assign rs        = instruction[25:21];
    assign rt        = instruction[20:16];
    assign rd        = instruction[15:11];
    assign shamt     = instruction[10:6];
    assign funct     = instruction[5:0];
    assign immediate = instruction[15:0];
    assign address   = instruction[25:0];

    assign imm_sext = sext16(immediate);
    assign imm_zext = {16'h0, immediate};

    // Decode opcode/funct into control signals, ALU op and second operand
    always_comb begin
        alu_op        = ALU_NONE;
        operand_b     = rt_content;
        reg_read      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch_signal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_read  = 1'b1;
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    // jr only redirects pc; nothing is written back
                    FN_JR:           reg_write = 1'b0;
                    default: begin
                        reg_read  = 1'b0;
                        reg_write = 1'b0;
                        reg_dst   = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                reg_read  = 1'b1;
                reg_write = (opcode != OP_SW);
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                operand_b = imm_sext;
                alu_op    = (opcode == OP_SLTI)  ? ALU_SLT  :
                            (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                reg_read  = 1'b1;
                reg_write = 1'b1;
                operand_b = imm_zext;
                alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  :
                            (opcode == OP_XORI) ? ALU_XOR : ALU_LUI;
            end
            OP_BEQ, OP_BNE: begin
                reg_read      = 1'b1;
                branch_signal = 1'b1;
                // Both branches take the jump when the result is zero
                alu_op        = (opcode == OP_BEQ) ? ALU_SUB : ALU_EQ;
            end
            default: ;
        endcase
    end

    mips_alu u_alu (
        .alu_op (alu_op),
        .a      (rs_content),
        .b      (operand_b),
        .shamt  (shamt),
        .result (alu_result)
    );

    // Next-pc priority: j, then jr, then taken branch, else sequential
    always_comb begin
        next_pc = pc + 32'd1;
        if (opcode == OP_J) begin
            next_pc = {6'b0, address};
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
            next_pc = rs_content;
        end else if (branch_signal && alu_result == 32'h0) begin
            next_pc = pc + 32'd1 + imm_sext;
        end
    end

    // Program counter register with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Directed, table-driven bench for mips_decode_execute.
module tb_mips_decode_execute;

    logic        clock;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] address;
    logic        reg_read, reg_write, reg_dst, mem_read, mem_write, branch_signal;
    logic [31:0] alu_result;

    int checks = 0;
    int errors = 0;

    mips_decode_execute #(.RESET_PC(32'h0)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instruction   (instruction),
        .rs_content    (rs_content),
        .rt_content    (rt_content),
        .pc            (pc),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .immediate     (immediate),
        .address       (address),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch_signal (branch_signal),
        .alu_result    (alu_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ctrl packing: {reg_read, reg_write, reg_dst, mem_read, mem_write, branch_signal}
    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic [31:0] instr;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic        chk_alu;
        logic [31:0] exp_alu;
        logic [5:0]  exp_ctrl;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] target);
        instruction = 32'h0800_0000 | target;
        rs_content  = 32'h0;
        rt_content  = 32'h0;
        tick();
    endtask

    initial begin
        // name, start_pc, instr, rs, rt, chk_alu, exp_alu, exp_ctrl, exp_pc
        vecs.push_back('{"add",      32'd3,  32'h0109_5020, 32'd5,         32'd3,         1'b1, 32'd8,         6'b111000, 32'd4});
        vecs.push_back('{"lw",       32'd5,  32'h8D0A_FFFC, 32'h100,       32'h0,         1'b1, 32'h0000_00FC, 6'b110100, 32'd6});
        vecs.push_back('{"sw",       32'd6,  32'hAD0A_0004, 32'h100,       32'h0,         1'b1, 32'h0000_0104, 6'b100010, 32'd7});
        vecs.push_back('{"beq_tkn",  32'd10, 32'h1022_FFFD, 32'd4,         32'd4,         1'b1, 32'h0,         6'b100001, 32'd8});
        vecs.push_back('{"beq_nt",   32'd10, 32'h1022_FFFD, 32'd4,         32'd5,         1'b1, 32'hFFFF_FFFF, 6'b100001, 32'd11});
        vecs.push_back('{"bne_tkn",  32'd10, 32'h1422_0002, 32'd4,         32'd5,         1'b1, 32'h0,         6'b100001, 32'd13});
        vecs.push_back('{"beq_wrap", 32'd1,  32'h1022_FFFD, 32'd9,         32'd9,         1'b1, 32'h0,         6'b100001, 32'hFFFF_FFFF});
        vecs.push_back('{"j",        32'd2,  32'h0800_0040, 32'h0,         32'h0,         1'b0, 32'h0,         6'b000000, 32'h40});
        vecs.push_back('{"jr",       32'd4,  32'h0020_0008, 32'h25,        32'h0,         1'b1, 32'h0,         6'b101000, 32'h25});
        vecs.push_back('{"sra",      32'd8,  32'h0002_1903, 32'h0,         32'h8000_0000, 1'b1, 32'hF800_0000, 6'b111000, 32'd9});
        vecs.push_back('{"srl",      32'd8,  32'h0002_1902, 32'h0,         32'h8000_0000, 1'b1, 32'h0800_0000, 6'b111000, 32'd9});
        vecs.push_back('{"sll",      32'd8,  32'h0002_07C0, 32'h0,         32'h1,         1'b1, 32'h8000_0000, 6'b111000, 32'd9});
        vecs.push_back('{"sltu",     32'd3,  32'h0022_182B, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         6'b111000, 32'd4});
        vecs.push_back('{"slt",      32'd3,  32'h0022_182A, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'h1,         6'b111000, 32'd4});
        vecs.push_back('{"sub",      32'd3,  32'h0022_1822, 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 6'b111000, 32'd4});
        vecs.push_back('{"nor",      32'd3,  32'h0022_1827, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1, 32'h0000_0F0F, 6'b111000, 32'd4});
        vecs.push_back('{"addi",     32'd3,  32'h2022_FFFF, 32'd10,        32'h0,         1'b1, 32'd9,         6'b110000, 32'd4});
        vecs.push_back('{"andi",     32'd3,  32'h3022_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_FFFF, 6'b110000, 32'd4});
        vecs.push_back('{"lui",      32'd3,  32'h3C02_1234, 32'hDEAD_BEEF, 32'h0,         1'b1, 32'h1234_0000, 6'b110000, 32'd4});
        vecs.push_back('{"slti",     32'd3,  32'h2822_FFFF, 32'hFFFF_FFFE, 32'h0,         1'b1, 32'h1,         6'b110000, 32'd4});
        vecs.push_back('{"sltiu",    32'd3,  32'h2C22_0001, 32'h0,         32'h0,         1'b1, 32'h1,         6'b110000, 32'd4});
        vecs.push_back('{"bad_op",   32'd3,  32'hFC22_1234, 32'd7,         32'd9,         1'b1, 32'h0,         6'b000000, 32'd4});
        vecs.push_back('{"bad_fn",   32'd3,  32'h0022_183F, 32'd7,         32'd9,         1'b1, 32'h0,         6'b000000, 32'd4});

        // Reset state and first edge after release
        reset_n     = 1'b0;
        instruction = 32'h0;
        rs_content  = 32'h0;
        rt_content  = 32'h0;
        #12;
        check("reset_pc", pc, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("first_edge_pc", pc, 32'h1);

        // Asynchronous reset mid-run from pc=7
        set_pc(32'd7);
        instruction = 32'h0;
        check("pre_reset_pc", pc, 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post_release_pc", pc, 32'h1);

        // Field split on add $10,$8,$9
        instruction = 32'h0109_5020;
        #1;
        check("f_opcode", {26'h0, opcode}, 32'h0);
        check("f_rs", {27'h0, rs}, 32'd8);
        check("f_rt", {27'h0, rt}, 32'd9);
        check("f_rd", {27'h0, rd}, 32'd10);
        check("f_shamt", {27'h0, shamt}, 32'd0);
        check("f_funct", {26'h0, funct}, 32'h20);
        check("f_imm", {16'h0, immediate}, 32'h5020);
        check("f_addr", {6'h0, address}, 32'h0109_5020);

        // Table: park pc at start_pc, apply vector, check comb outputs then next pc
        foreach (vecs[i]) begin
            set_pc(vecs[i].start_pc);
            check({vecs[i].name, "_start"}, pc, vecs[i].start_pc);
            instruction = vecs[i].instr;
            rs_content  = vecs[i].rs_v;
            rt_content  = vecs[i].rt_v;
            #1;
            if (vecs[i].chk_alu)
                check({vecs[i].name, "_alu"}, alu_result, vecs[i].exp_alu);
            check({vecs[i].name, "_ctrl"},
                  {26'h0, reg_read, reg_write, reg_dst, mem_read, mem_write, branch_signal},
                  {26'h0, vecs[i].exp_ctrl});
            tick();
            check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
        end

        // Back-to-back branch sequence: beq taken then bne not taken
        set_pc(32'd20);
        instruction = 32'h1022_0003;
        rs_content  = 32'd6;
        rt_content  = 32'd6;
        tick();
        check("seq_beq_pc", pc, 32'd24);
        instruction = 32'h1422_0005;
        tick();
        check("seq_bne_pc", pc, 32'd25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
